// File: rtl/audio_pkg.sv
// Shared audio constants and the capture FSM encoding, common to the
// inbound capture path and the DAC output path.
package audio_pkg;

    localparam int unsigned SAMPLE_W_DEF = 32;
    localparam int unsigned WAVE_W_DEF   = 7;
    localparam logic [6:0]  WAVE_MID     = 7'd64;

    typedef logic [1:0] cap_state_t;

    localparam cap_state_t CAP_IDLE    = 2'd0;
    localparam cap_state_t CAP_READ    = 2'd1;
    localparam cap_state_t CAP_CAPTURE = 2'd2;

endpackage

// File: rtl/audio_sample_fifo.sv
// Circular sample buffer with valid/ready pop and push/full; the head word
// is presented combinationally and holds until popped.
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned WIDTH = WAVE_W_DEF,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         i_clock,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop_ready,
    output logic [WIDTH-1:0]             o_head_data,
    output logic                         o_head_valid,
    output logic                         o_full,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full       = (r_count == FULL_CNT);
    assign o_head_valid = (r_count != '0);
    assign o_head_data  = r_mem[r_rd_ptr];
    assign o_count      = r_count;

    // A push into a full buffer is accepted only when a pop frees the slot on the same edge.
    assign w_pop  = i_pop_ready && o_head_valid;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/audio_in_capture.sv
// Drains ADC samples from the Audio_Controller, converts them to offset-binary
// wave words in a FIFO and meters the peak level. Define AUDIO_IN_MONO_MIX_EN
// to use (left + right) / 2 as the source instead of the left channel.
module audio_in_capture
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W   = SAMPLE_W_DEF,
    parameter int unsigned WAVE_W     = WAVE_W_DEF,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned PEAK_DECAY = 4800
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                audio_in_available,
    input  logic [SAMPLE_W-1:0] left_channel_audio_in,
    input  logic [SAMPLE_W-1:0] right_channel_audio_in,
    output logic                read_audio_in,
    output logic [WAVE_W-1:0]   wave_in,
    output logic                wave_valid,
    input  logic                wave_ready,
    output logic [5:0]          peak_level,
    output logic                overflow
);

    localparam int unsigned   AW         = $clog2(FIFO_DEPTH);
    localparam int unsigned   DW         = $clog2(PEAK_DECAY + 1);
    localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [DW-1:0] DECAY_LAST = DW'(PEAK_DECAY - 1);

    cap_state_t          r_state;
    logic [5:0]          r_peak;
    logic                r_overflow;
    logic [DW-1:0]       r_decay_cnt;

    logic [SAMPLE_W-1:0] w_src;
    logic [SAMPLE_W-1:0] w_abs;
    logic [5:0]          w_mag;
    logic [WAVE_W-1:0]   w_wave;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_has_room;
    logic                w_decay_wrap;
    logic [AW:0]         w_count;
    logic [AW:0]         w_occ_after;
    logic                w_unused_abs_lo;

`ifdef AUDIO_IN_MONO_MIX_EN
    logic signed [SAMPLE_W:0] w_sum;
    logic                     w_unused_sum_lsb;

    // One extra bit keeps the sum exact; dropping its LSB is the arithmetic >>> 1.
    assign w_sum = $signed({left_channel_audio_in[SAMPLE_W-1], left_channel_audio_in})
                 + $signed({right_channel_audio_in[SAMPLE_W-1], right_channel_audio_in});
    assign w_src            = w_sum[SAMPLE_W:1];
    assign w_unused_sum_lsb = w_sum[0];
`else
    logic w_unused_right;

    assign w_src          = left_channel_audio_in;
    assign w_unused_right = ^right_channel_audio_in;
`endif

    assign w_wave = {~w_src[SAMPLE_W-1], w_src[SAMPLE_W-2 -: WAVE_W-1]};

    // Only the most negative sample keeps its MSB after negation; it saturates the meter.
    assign w_abs           = w_src[SAMPLE_W-1] ? (-w_src) : w_src;
    assign w_mag           = w_abs[SAMPLE_W-1] ? 6'h3F : w_abs[SAMPLE_W-2 -: 6];
    assign w_unused_abs_lo = ^w_abs[SAMPLE_W-8:0];

    assign w_pop        = wave_valid && wave_ready;
    assign w_occ_after  = w_count - {{AW{1'b0}}, w_pop};
    assign w_has_room   = (w_occ_after < DEPTH_CNT);
    assign w_push       = (r_state == CAP_CAPTURE);
    assign w_decay_wrap = (r_decay_cnt == DECAY_LAST);

    assign read_audio_in = (r_state == CAP_READ);
    assign peak_level    = r_peak;
    assign overflow      = r_overflow;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= CAP_IDLE;
            r_peak      <= '0;
            r_overflow  <= 1'b0;
            r_decay_cnt <= '0;
        end else begin
            case (r_state)
                CAP_IDLE: begin
                    if (audio_in_available && w_has_room) begin
                        r_state <= CAP_READ;
                    end
                    if (audio_in_available && w_full && !w_pop) begin
                        r_overflow <= 1'b1;
                    end
                end
                CAP_READ: begin
                    r_state <= CAP_CAPTURE;
                end
                CAP_CAPTURE: begin
                    r_state     <= CAP_IDLE;
                    r_decay_cnt <= w_decay_wrap ? '0 : r_decay_cnt + DW'(1);
                    if (w_mag > r_peak) begin
                        r_peak <= w_mag;
                    end else if (w_decay_wrap && (r_peak != '0)) begin
                        r_peak <= r_peak - 6'd1;
                    end
                end
                default: begin
                    r_state <= CAP_IDLE;
                end
            endcase
        end
    end

    audio_sample_fifo #(
        .WIDTH (WAVE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clock      (clock),
        .i_rst_n      (reset),
        .i_push       (w_push),
        .i_push_data  (w_wave),
        .i_pop_ready  (wave_ready),
        .o_head_data  (wave_in),
        .o_head_valid (wave_valid),
        .o_full       (w_full),
        .o_count      (w_count)
    );

endmodule
